// File: rtl/time_cnt_pkg.sv
// Shared types and helpers for the time counter chain.
package time_cnt_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PAUSE = 2'd1,
    LOAD  = 2'd2
  } fsm_state_e;

  localparam int DEF_CW = 8;
  localparam int DIG_W  = 4;

  // Returns {tens, units}; only meaningful for values below 100.
  function automatic logic [2*DIG_W-1:0] bin2dec(input logic [7:0] v);
    return {DIG_W'(v / 8'd10), DIG_W'(v % 8'd10)};
  endfunction

endpackage

// File: rtl/time_counter_stage.sv
// One modulo-LIMIT stage of the counter chain with load clamp and decimal split.
module time_counter_stage
  import time_cnt_pkg::*;
#(
  parameter int            CW    = DEF_CW,
  parameter logic [CW-1:0] LIMIT = CW'(60)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_en,
  input  logic             dir,
  input  logic             load_en,
  input  logic [CW-1:0]    load_val,
  output logic [CW-1:0]    count,
  output logic             terminal,
  output logic [DIG_W-1:0] tens,
  output logic [DIG_W-1:0] units
);

  if (LIMIT < 2 || LIMIT > 100) begin : g_bad_limit
    $error("time_counter_stage: LIMIT must be within 2..100");
  end

  localparam logic [CW-1:0] TOP = LIMIT - CW'(1);

  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] load_clamped;
  logic [7:0]    val8;

  assign load_clamped = (load_val >= LIMIT) ? TOP : load_val;
  assign terminal     = dir ? (count_q == '0) : (count_q == TOP);

  always_comb begin
    count_d = count_q;
    if (load_en) begin
      count_d = load_clamped;
    end else if (step_en) begin
      if (terminal) count_d = dir ? TOP : '0;
      else          count_d = dir ? (count_q - CW'(1)) : (count_q + CW'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count         = count_q;
  assign val8          = 8'(count_q);
  assign {tens, units} = bin2dec(val8);

endmodule

// File: rtl/time_counter_chain.sv
// Multi-stage modulo counter chain with load handshake, pause and ripple carry/borrow.
// Optional alarm comparator enabled by defining TIME_COUNTER_ALARM_EN.
module time_counter_chain
  import time_cnt_pkg::*;
#(
  parameter int                         NUM_STAGES = 3,
  parameter int                         CW         = DEF_CW,
  parameter logic [NUM_STAGES*CW-1:0]   LIMITS     = {8'd24, 8'd60, 8'd60}
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tick_en,
  input  logic                     dir,
  input  logic                     hold,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [NUM_STAGES*CW-1:0] load_data,
  output logic [NUM_STAGES*CW-1:0] count_out,
  output logic [NUM_STAGES*4-1:0]  bcd_t,
  output logic [NUM_STAGES*4-1:0]  bcd_u,
  output logic                     wrap_out,
`ifdef TIME_COUNTER_ALARM_EN
  input  logic                     alarm_set,
  input  logic [NUM_STAGES*CW-1:0] alarm_data,
  output logic                     alarm_out,
`endif
  output logic [1:0]               state_out
);

  fsm_state_e state_q, state_d;
  logic       load_acc;
  logic       cnt_en;
  logic [NUM_STAGES:0]   carry;
  logic [NUM_STAGES-1:0] term;

  // Ready is gated by reset so it reads 0 while rst_n is held low.
  assign load_ready = rst_n & (state_q != LOAD);
  assign load_acc   = load_valid & load_ready;
  // hold suppresses a tick even in the cycle before PAUSE is entered.
  assign cnt_en     = (state_q == RUN) & tick_en & ~hold & ~load_acc;

  assign carry[0] = cnt_en;
  assign wrap_out = carry[NUM_STAGES];

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    time_counter_stage #(
      .CW    (CW),
      .LIMIT (LIMITS[g*CW +: CW])
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .step_en  (carry[g]),
      .dir      (dir),
      .load_en  (load_acc),
      .load_val (load_data[g*CW +: CW]),
      .count    (count_out[g*CW +: CW]),
      .terminal (term[g]),
      .tens     (bcd_t[g*4 +: 4]),
      .units    (bcd_u[g*4 +: 4])
    );
    assign carry[g+1] = carry[g] & term[g];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN, PAUSE: begin
        if (load_acc)  state_d = LOAD;
        else if (hold) state_d = PAUSE;
        else           state_d = RUN;
      end
      LOAD:    state_d = hold ? PAUSE : RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  assign state_out = state_q;

`ifdef TIME_COUNTER_ALARM_EN
  logic [NUM_STAGES*CW-1:0] alarm_val_q, alarm_val_d, alarm_clamp;
  logic                     upd_q, alarm_pulse_q;

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_alarm_clamp
    assign alarm_clamp[g*CW +: CW] =
      (alarm_data[g*CW +: CW] >= LIMITS[g*CW +: CW]) ? (LIMITS[g*CW +: CW] - CW'(1))
                                                      : alarm_data[g*CW +: CW];
  end

  assign alarm_val_d = alarm_set ? alarm_clamp : alarm_val_q;

  // upd_q marks a cycle whose count came from a tick or load; only then may a match pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_val_q   <= '0;
      upd_q         <= 1'b0;
      alarm_pulse_q <= 1'b0;
    end else begin
      alarm_val_q   <= alarm_val_d;
      upd_q         <= cnt_en | load_acc;
      alarm_pulse_q <= upd_q & (count_out == alarm_val_q);
    end
  end

  assign alarm_out = alarm_pulse_q;
`endif

endmodule

// File: tb/tb_time_counter_chain.sv
// Self-checking bench: directed table, reset sequence and randomized run against a mixed-radix model.
module tb_time_counter_chain;
  localparam int NS = 3;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n, tick_en, dir, hold, load_valid, load_ready, wrap_out;
  logic [NS*CW-1:0] load_data, count_out;
  logic [NS*4-1:0]  bcd_t, bcd_u;
  logic [1:0]       state_out;
`ifdef TIME_COUNTER_ALARM_EN
  logic             alarm_set, alarm_out;
  logic [NS*CW-1:0] alarm_data;
`endif

  always #5 clk = ~clk;

  time_counter_chain dut (
    .clk(clk), .rst_n(rst_n), .tick_en(tick_en), .dir(dir), .hold(hold),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .count_out(count_out), .bcd_t(bcd_t), .bcd_u(bcd_u), .wrap_out(wrap_out),
`ifdef TIME_COUNTER_ALARM_EN
    .alarm_set(alarm_set), .alarm_data(alarm_data), .alarm_out(alarm_out),
`endif
    .state_out(state_out)
  );

  int checks = 0;
  int errors = 0;
  int lim[NS] = '{60, 60, 24};
  int mv[NS];
  int mst;  // 0 run, 1 pause, 2 load

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int period();
    int p = 1;
    for (int i = 0; i < NS; i++) p *= lim[i];
    return p;
  endfunction

  function automatic int to_idx();
    int r = 0;
    for (int i = NS - 1; i >= 0; i--) r = r * lim[i] + mv[i];
    return r;
  endfunction

  task automatic from_idx(input int x);
    for (int i = 0; i < NS; i++) begin
      mv[i] = x % lim[i];
      x     = x / lim[i];
    end
  endtask

  function automatic bit model_counts();
    return (mst == 0) && tick_en && !hold && !(load_valid && mst != 2);
  endfunction

  function automatic bit model_wrap();
    int idx = to_idx();
    return model_counts() && (dir ? (idx == 0) : (idx == period() - 1));
  endfunction

  task automatic check_model();
    for (int i = 0; i < NS; i++) begin
      chk($sformatf("count[%0d]", i), int'(count_out[i*CW +: CW]), mv[i]);
      chk($sformatf("bcd_t[%0d]", i), int'(bcd_t[i*4 +: 4]), mv[i] / 10);
      chk($sformatf("bcd_u[%0d]", i), int'(bcd_u[i*4 +: 4]), mv[i] % 10);
    end
    chk("state", int'(state_out), mst);
    chk("ready", int'(load_ready), (mst != 2) ? 1 : 0);
    chk("wrap", int'(wrap_out), model_wrap() ? 1 : 0);
  endtask

  task automatic model_edge();
    bit acc = load_valid && (mst != 2);
    int p   = period();
    if (acc) begin
      for (int i = 0; i < NS; i++) begin
        int v = int'(load_data[i*CW +: CW]);
        mv[i] = (v >= lim[i]) ? lim[i] - 1 : v;
      end
    end else if (model_counts()) begin
      from_idx(dir ? (to_idx() + p - 1) % p : (to_idx() + 1) % p);
    end
    mst = acc ? 2 : (hold ? 1 : 0);
  endtask

  task automatic drive(input bit te, input bit dr, input bit hd, input bit lv,
                       input int h, input int m, input int s);
    tick_en = te; dir = dr; hold = hd; load_valid = lv;
    load_data = {8'(h), 8'(m), 8'(s)};
  endtask

  task automatic step();
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  typedef struct {
    bit te, dr, hd, lv;
    int lh, lm, ls;
    int eh, em, es;
    bit ew, er;
    int est;
  } vec_t;

  function automatic vec_t mk(bit te, bit dr, bit hd, bit lv, int lh, int lm, int ls,
                              int eh, int em, int es, bit ew, bit er, int est);
    vec_t v;
    v.te = te; v.dr = dr; v.hd = hd; v.lv = lv;
    v.lh = lh; v.lm = lm; v.ls = ls;
    v.eh = eh; v.em = em; v.es = es;
    v.ew = ew; v.er = er; v.est = est;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          te dr hd lv  load       expected count  wrap rdy state
    tbl.push_back(mk(0,0,0,1, 23,59,58,  0, 0, 0,  0,1,0));
    tbl.push_back(mk(0,0,0,0,  0, 0, 0, 23,59,58,  0,0,2));
    tbl.push_back(mk(1,0,0,0,  0, 0, 0, 23,59,58,  0,1,0));
    tbl.push_back(mk(1,0,0,0,  0, 0, 0, 23,59,59,  1,1,0));
    tbl.push_back(mk(0,0,0,0,  0, 0, 0,  0, 0, 0,  0,1,0));
    tbl.push_back(mk(0,0,0,1,  0, 0, 0,  0, 0, 0,  0,1,0));
    tbl.push_back(mk(0,0,0,0,  0, 0, 0,  0, 0, 0,  0,0,2));
    tbl.push_back(mk(1,1,0,0,  0, 0, 0,  0, 0, 0,  1,1,0));
    tbl.push_back(mk(1,1,0,0,  0, 0, 0, 23,59,59,  0,1,0));
    tbl.push_back(mk(0,0,0,0,  0, 0, 0, 23,59,58,  0,1,0));
    tbl.push_back(mk(0,0,0,1, 30,75,99, 23,59,58,  0,1,0));
    tbl.push_back(mk(0,0,0,0,  0, 0, 0, 23,59,59,  0,0,2));
    tbl.push_back(mk(0,0,0,1,  0, 0,10, 23,59,59,  0,1,0));
    tbl.push_back(mk(0,0,0,0,  0, 0, 0,  0, 0,10,  0,0,2));
    tbl.push_back(mk(1,0,0,1,  1, 2, 3,  0, 0,10,  0,1,0));
    tbl.push_back(mk(0,0,1,0,  0, 0, 0,  1, 2, 3,  0,0,2));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(1,0,1,0, 0, 0, 0,  1, 2, 3,  0,1,1));
    tbl.push_back(mk(0,0,0,0,  0, 0, 0,  1, 2, 3,  0,1,1));
    tbl.push_back(mk(1,0,0,0,  0, 0, 0,  1, 2, 3,  0,1,0));
    tbl.push_back(mk(0,0,0,1, 12,34,56,  1, 2, 4,  0,1,0));
    tbl.push_back(mk(0,0,0,0,  0, 0, 0, 12,34,56,  0,0,2));
    tbl.push_back(mk(0,0,0,0,  0, 0, 0, 12,34,56,  0,1,0));

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
`ifdef TIME_COUNTER_ALARM_EN
    alarm_set = 1'b0; alarm_data = '0;
`endif
    for (int i = 0; i < NS; i++) mv[i] = 0;
    mst = 0;
    #12;
    chk("rst_ready", int'(load_ready), 0);
    chk("rst_count", int'(count_out), 0);
    chk("rst_wrap", int'(wrap_out), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (tbl[r]) begin
      drive(tbl[r].te, tbl[r].dr, tbl[r].hd, tbl[r].lv, tbl[r].lh, tbl[r].lm, tbl[r].ls);
      @(negedge clk);
      chk($sformatf("tbl%0d_h", r), int'(count_out[2*CW +: CW]), tbl[r].eh);
      chk($sformatf("tbl%0d_m", r), int'(count_out[1*CW +: CW]), tbl[r].em);
      chk($sformatf("tbl%0d_s", r), int'(count_out[0*CW +: CW]), tbl[r].es);
      chk($sformatf("tbl%0d_wrap", r), int'(wrap_out), int'(tbl[r].ew));
      chk($sformatf("tbl%0d_ready", r), int'(load_ready), int'(tbl[r].er));
      chk($sformatf("tbl%0d_state", r), int'(state_out), tbl[r].est);
      check_model();
      @(posedge clk);
      model_edge();
      #1;
    end

    // Asynchronous reset mid-cycle while counting at 12:34:56.
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_count", int'(count_out), 0);
    chk("arst_ready", int'(load_ready), 0);
    chk("arst_state", int'(state_out), 0);
    chk("arst_bcd", int'({bcd_t, bcd_u}), 0);
    for (int i = 0; i < NS; i++) mv[i] = 0;
    mst = 0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("post_rst_tick", int'(count_out), 1);
    @(posedge clk); #1;

    // Randomized run against the mixed-radix model.
    for (int c = 0; c < 1500; c++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 5) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 127));
      step();
    end

`ifdef TIME_COUNTER_ALARM_EN
    begin
      int pulses = 0;
      int pulse_k = -1;
      drive(0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      alarm_set = 1'b1; alarm_data = {8'd0, 8'd0, 8'd3};
      @(posedge clk); #1;
      alarm_set = 1'b0;
      for (int k = 0; k < 15; k++) begin
        drive(k < 3, 0, k >= 3, 0, 0, 0, 0);
        @(negedge clk);
        if (alarm_out) begin
          pulses++;
          pulse_k = k;
        end
        @(posedge clk); #1;
      end
      chk("alarm_pulses", pulses, 1);
      chk("alarm_cycle", pulse_k, 4);
      chk("alarm_count", int'(count_out), 3);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
